// File: rtl/core_sequencer.sv
// Multicycle control FSM for the RV32IMA core: sequences fetch/decode/execute/memory/writeback
// and the trap path with one-cycle start pulses, and keeps the retire/cycle counters and a stage watchdog.
module core_sequencer #(
   parameter int unsigned CNT_W          = 64,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             run,
   input  logic             halt_req,
   output logic             fetch_enabled,
   input  logic             fetch_completed,
   output logic             decode_enabled,
   input  logic             decode_completed,
   output logic             exec_enabled,
   input  logic             exec_completed,
   input  logic             exception,
   input  logic             needs_mem,
   input  logic             writes_to_reg,
   output logic             mem_enabled,
   input  logic             mem_completed,
   output logic             write_enabled,
   input  logic             write_completed,
   output logic             trap_enabled,
   input  logic             trap_completed,
   output logic [2:0]       state,
   output logic             busy,
   output logic             timeout_err,
   output logic [CNT_W-1:0] instret,
   output logic [CNT_W-1:0] cycle_count
);

   localparam int unsigned WD_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned N_STAGE = 6;
   localparam int unsigned EN_FETCH  = 0;
   localparam int unsigned EN_DECODE = 1;
   localparam int unsigned EN_EXEC   = 2;
   localparam int unsigned EN_MEM    = 3;
   localparam int unsigned EN_WRITE  = 4;
   localparam int unsigned EN_TRAP   = 5;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WRITE  = 3'd5,
      S_TRAP   = 3'd6,
      S_ERR    = 3'd7
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [N_STAGE-1:0]   r_en;
   logic [N_STAGE-1:0]   w_en_nxt;
   logic [WD_W-1:0]      r_wd;
   logic [WD_W-1:0]      w_wd_nxt;
   logic                 r_wr_lat;
   logic                 w_wr_lat_nxt;
   logic                 r_timeout_err;
   logic                 w_timeout_nxt;
   logic                 r_busy;
   logic                 w_busy_nxt;
   logic [CNT_W-1:0]     r_instret;
   logic [CNT_W-1:0]     r_cycle_count;
   logic                 w_pulse;
   logic                 w_done;
   logic                 w_retire;
   logic                 w_instr_end;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state       <= S_IDLE;
         r_en          <= '0;
         r_wd          <= '0;
         r_wr_lat      <= 1'b0;
         r_timeout_err <= 1'b0;
         r_busy        <= 1'b0;
         r_instret     <= '0;
         r_cycle_count <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_en          <= w_en_nxt;
         r_wd          <= w_wd_nxt;
         r_wr_lat      <= w_wr_lat_nxt;
         r_timeout_err <= w_timeout_nxt;
         r_busy        <= w_busy_nxt;
         if (w_retire) begin
            r_instret <= r_instret + CNT_W'(1);
         end
         if (r_busy) begin
            r_cycle_count <= r_cycle_count + CNT_W'(1);
         end
      end
   end

   // Next-state, watchdog and enable-pulse decode
   always_comb begin
      w_state_nxt   = r_state;
      w_en_nxt      = '0;
      w_wd_nxt      = r_wd;
      w_wr_lat_nxt  = r_wr_lat;
      w_timeout_nxt = r_timeout_err;
      w_retire      = 1'b0;
      w_instr_end   = 1'b0;
      w_done        = 1'b0;
      w_busy_nxt    = 1'b0;
      w_pulse       = |r_en;

      case (r_state)
         S_FETCH:  w_done = fetch_completed;
         S_DECODE: w_done = decode_completed;
         S_EXEC:   w_done = exec_completed;
         S_MEM:    w_done = mem_completed;
         S_WRITE:  w_done = write_completed;
         S_TRAP:   w_done = trap_completed;
         default:  w_done = 1'b0;
      endcase

      if (r_state == S_IDLE) begin
         if (run) begin
            w_state_nxt = S_FETCH;
         end
      end else if ((r_state != S_ERR) && !w_pulse) begin
         // Completion beats the watchdog when both land on the same cycle
         if (w_done) begin
            case (r_state)
               S_FETCH:  w_state_nxt = S_DECODE;
               S_DECODE: w_state_nxt = S_EXEC;
               S_EXEC: begin
                  w_wr_lat_nxt = writes_to_reg;
                  if (exception) begin
                     w_state_nxt = S_TRAP;
                  end else if (needs_mem) begin
                     w_state_nxt = S_MEM;
                  end else if (writes_to_reg) begin
                     w_state_nxt = S_WRITE;
                  end else begin
                     w_retire = 1'b1;
                  end
               end
               S_MEM: begin
                  if (r_wr_lat) begin
                     w_state_nxt = S_WRITE;
                  end else begin
                     w_retire = 1'b1;
                  end
               end
               S_WRITE:  w_retire    = 1'b1;
               S_TRAP:   w_instr_end = 1'b1;
               default:  w_state_nxt = r_state;
            endcase
            if (w_retire || w_instr_end) begin
               w_state_nxt = halt_req ? S_IDLE : S_FETCH;
            end
         end else if (r_wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
            w_state_nxt   = S_ERR;
            w_timeout_nxt = 1'b1;
         end else begin
            w_wd_nxt = r_wd + WD_W'(1);
         end
      end

      // Every state change into a stage issues that stage's single start pulse
      if (w_state_nxt != r_state) begin
         w_wd_nxt = '0;
         case (w_state_nxt)
            S_FETCH:  w_en_nxt[EN_FETCH]  = 1'b1;
            S_DECODE: w_en_nxt[EN_DECODE] = 1'b1;
            S_EXEC:   w_en_nxt[EN_EXEC]   = 1'b1;
            S_MEM:    w_en_nxt[EN_MEM]    = 1'b1;
            S_WRITE:  w_en_nxt[EN_WRITE]  = 1'b1;
            S_TRAP:   w_en_nxt[EN_TRAP]   = 1'b1;
            default:  w_en_nxt = '0;
         endcase
      end

      w_busy_nxt = (w_state_nxt != S_IDLE) && (w_state_nxt != S_ERR);
   end

   assign fetch_enabled  = r_en[EN_FETCH];
   assign decode_enabled = r_en[EN_DECODE];
   assign exec_enabled   = r_en[EN_EXEC];
   assign mem_enabled    = r_en[EN_MEM];
   assign write_enabled  = r_en[EN_WRITE];
   assign trap_enabled   = r_en[EN_TRAP];
   assign state          = r_state;
   assign busy           = r_busy;
   assign timeout_err    = r_timeout_err;
   assign instret        = r_instret;
   assign cycle_count    = r_cycle_count;

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Multicycle control FSM for the RV32IMA core. Steps one instruction at a time through fetch, decode, execute, memory and writeback, plus a trap path, using one-cycle enable pulses and the completed flags of each stage unit. Decides the path for each instruction from decoded control flags. Keeps the instret and cycle counters and a per-stage watchdog.

Parameters:
CNT_W, 64, width of the instret and cycle_count counters
TIMEOUT_CYCLES, 1024, maximum wait cycles per stage before entering the error state

Ports:
clk  input  1  clock
rstn  input  1  synchronous active-low reset
run  input  1  start request; sampled only in S_IDLE
halt_req  input  1  stop after the current instruction retires or traps
fetch_enabled  output  1  one-cycle start pulse to the fetch unit
fetch_completed  input  1  fetch done
decode_enabled  output  1  one-cycle start pulse to the decoder
decode_completed  input  1  decoder done
exec_enabled  output  1  one-cycle start pulse to the execute unit
exec_completed  input  1  execute done
exception  input  1  execute raised a trap; qualified by exec_completed
needs_mem  input  1  decoded is_load, is_store, lr or rv32a
writes_to_reg  input  1  decoded writes_to_reg
mem_enabled  output  1  one-cycle start pulse to the memory unit
mem_completed  input  1  memory done
write_enabled  output  1  one-cycle start pulse to the register writeback unit
write_completed  input  1  writeback done
trap_enabled  output  1  one-cycle start pulse to the trap/CSR unit
trap_completed  input  1  trap entry done
state  output  3  current state encoding
busy  output  1  high when state is not S_IDLE and not S_ERR
timeout_err  output  1  sticky watchdog error flag
instret  output  CNT_W  count of retired instructions
cycle_count  output  CNT_W  count of busy cycles

Behaviour:
- Reset: when rstn=0 at a clk edge:
  - state=S_IDLE; all *_enabled=0.
  - timeout_err=0; instret=0; cycle_count=0; watchdog=0.
  - Reset applies mid-operation; an in-flight stage is abandoned.
- State encodings: S_IDLE=0, S_FETCH=1, S_DECODE=2, S_EXEC=3, S_MEM=4, S_WRITE=5, S_TRAP=6, S_ERR=7.
- Handshake:
  - Entering a stage state asserts its *_enabled for exactly that first cycle. All enables are registered.
  - The matching completed input is ignored in the pulse cycle.
  - The stage completes on the first later cycle with completed=1. Stale high levels are therefore accepted, which is legal for units that hold completed high after the first operation.
  - Stage latency is at least 1 cycle. The controller adds 0 cycles between a completion and the next enable pulse, because the next state's pulse is issued on the following edge.
- Transitions:
  - S_IDLE: run=1 -> S_FETCH.
  - S_FETCH done -> S_DECODE.
  - S_DECODE done -> S_EXEC.
  - S_EXEC done:
    - exception=1 -> S_TRAP (exception takes priority over needs_mem and writes_to_reg).
    - else needs_mem=1 -> S_MEM.
    - else writes_to_reg=1 -> S_WRITE.
    - else retire.
  - S_MEM done: writes_to_reg=1 -> S_WRITE; else retire.
  - S_WRITE done -> retire.
  - S_TRAP done -> no instret increment; then the same halt check as retire.
  - S_ERR: terminal until reset.
- Retire: instret += 1 (wraps modulo 2^CNT_W). Then halt_req=1 -> S_IDLE; else -> S_FETCH.
- Sampling rules:
  - needs_mem and writes_to_reg are sampled at the S_EXEC completion edge and latched for the S_MEM decision.
  - halt_req is sampled only at retire or trap completion. It has no effect mid-instruction.
  - run is ignored outside S_IDLE.
- cycle_count: increments every cycle that busy=1, including pulse cycles. Wraps modulo 2^CNT_W.
- Watchdog:
  - Cleared on every enable pulse; increments each waiting cycle.
  - Reaching TIMEOUT_CYCLES before completion -> S_ERR with timeout_err=1 (sticky). No further enable pulses are issued.
  - A completion in the same cycle the limit is reached wins; no error is raised.

Test Plan:
- addi path: run=1; every unit completes 1 cycle after its enable; needs_mem=0, writes_to_reg=1 -> pulse order fetch, decode, exec, write; each next pulse 2 cycles after the previous; instret=1.
- lw path: needs_mem=1, writes_to_reg=1 -> exec, then mem, then write; sw with writes_to_reg=0 -> mem then retire with no write pulse; instret increments by 1 each.
- Branch path: needs_mem=0, writes_to_reg=0 -> retire directly after exec; the next fetch pulse follows; no mem or write pulse.
- Exception: exception=1 together with exec_completed and needs_mem=1 -> trap_enabled pulse, no mem pulse; instret unchanged; fetch resumes after trap_completed.
- halt_req=1 asserted during S_MEM -> instruction finishes; state=0 (S_IDLE) and busy=0 after retire; cycle_count frozen; run=1 restarts fetch.
- Watchdog: TIMEOUT_CYCLES=8, decode_completed held 0 -> state=7 (S_ERR) and timeout_err=1 after 8 wait cycles, no further pulses; rstn=0 for one cycle -> all outputs return to reset values.
